// File: rtl/div_pkg.sv
// Constants and types shared between the averaging front end and the divider.
// The widths here must match the divider's dividend/divisor ports.
package div_pkg;

    localparam int DIV_SW = 8;
    localparam int DIV_AW = 22;
    localparam int DIV_BW = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } issue_state_t;

endpackage

// File: rtl/avg_acc.sv
// Frame accumulator: sums samples, saturates the count, and closes frames
// towards the pending register (holding the closed frame if it is occupied).
module avg_acc
    import div_pkg::*;
#(
    parameter int SW = DIV_SW,
    parameter int AW = DIV_AW,
    parameter int BW = DIV_BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [SW-1:0] s_data,
    input  logic          f_end,
    input  logic          pend_free,
    output logic          s_ready,
    output logic          xfer,
    output logic [AW-1:0] xfer_sum,
    output logic [BW-1:0] xfer_count,
    output logic          zero_err,
    output logic          sat_err
);

    logic [AW-1:0] sum;
    logic [BW-1:0] count;
    logic          hold;

    logic          take;
    logic          drop;
    logic          close_frame;
    logic          close_empty;
    logic [AW-1:0] sum_nx;
    logic [BW-1:0] cnt_nx;

    function automatic logic cnt_full(input logic [BW-1:0] c);
        return &c;
    endfunction

    always_comb begin
        take        = !hold && s_valid && !cnt_full(count);
        drop        = !hold && s_valid && cnt_full(count);
        sum_nx      = take ? sum + AW'(s_data) : sum;
        cnt_nx      = take ? count + BW'(1) : count;
        close_frame = !hold && f_end && (cnt_nx != '0);
        close_empty = !hold && f_end && (cnt_nx == '0);
        // A held frame already sits in sum/count; a fresh close forwards the
        // value including any sample arriving in the same cycle.
        xfer        = hold ? pend_free : (close_frame && pend_free);
        xfer_sum    = hold ? sum : sum_nx;
        xfer_count  = hold ? count : cnt_nx;
    end

    assign s_ready = !hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum      <= '0;
            count    <= '0;
            hold     <= 1'b0;
            zero_err <= 1'b0;
            sat_err  <= 1'b0;
        end else begin
            zero_err <= close_empty;
            if (drop) begin
                sat_err <= 1'b1;
            end
            if (xfer) begin
                sum   <= '0;
                count <= '0;
                hold  <= 1'b0;
            end else if (close_frame) begin
                sum   <= sum_nx;
                count <= cnt_nx;
                hold  <= 1'b1;
            end else begin
                sum   <= sum_nx;
                count <= cnt_nx;
            end
        end
    end

endmodule

// File: rtl/avg_feed.sv
// Averaging front end: accumulates sample frames and hands {sum,count} to a
// divider through a one-entry pending register and a small issue FSM.
module avg_feed
    import div_pkg::*;
#(
    parameter int SW = DIV_SW,
    parameter int AW = DIV_AW,
    parameter int BW = DIV_BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [SW-1:0] s_data,
    input  logic          f_end,
    output logic          s_ready,
    output logic          in_en,
    output logic [AW-1:0] dividend,
    output logic [BW-1:0] divisor,
    input  logic          busy,
    input  logic          out_en,
    output logic          zero_err,
    output logic          sat_err
);

    issue_state_t  state;
    issue_state_t  state_nx;

    logic          pend_vld;
    logic [AW-1:0] pend_sum;
    logic [BW-1:0] pend_cnt;

    logic          vacate;
    logic          pend_free;
    logic          xfer;
    logic [AW-1:0] xfer_sum;
    logic [BW-1:0] xfer_cnt;

    // The divider takes the operands on the edge it raises busy.
    assign vacate    = (state == REQ) && busy;
    assign pend_free = !pend_vld || vacate;

    avg_acc #(
        .SW (SW),
        .AW (AW),
        .BW (BW)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .f_end      (f_end),
        .pend_free  (pend_free),
        .s_ready    (s_ready),
        .xfer       (xfer),
        .xfer_sum   (xfer_sum),
        .xfer_count (xfer_cnt),
        .zero_err   (zero_err),
        .sat_err    (sat_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_sum <= '0;
            pend_cnt <= '0;
        end else if (xfer) begin
            pend_vld <= 1'b1;
            pend_sum <= xfer_sum;
            pend_cnt <= xfer_cnt;
        end else if (vacate) begin
            pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pend_vld) state_nx = REQ;
            REQ:     if (busy)     state_nx = WAIT;
            WAIT:    if (out_en)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_en    = (state == REQ);
    assign dividend = pend_vld ? pend_sum : '0;
    assign divisor  = pend_vld ? pend_cnt : '0;

endmodule

// File: tb/tb_avg_feed.sv
// Bench for avg_feed: frame-level reference model, a divider model that
// answers requests, directed scenarios and a randomized frame stream.
module tb_avg_feed;
    import div_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic [DIV_SW-1:0] s_data = '0;
    logic              f_end = 1'b0;
    logic              s_ready;
    logic              in_en;
    logic [DIV_AW-1:0] dividend;
    logic [DIV_BW-1:0] divisor;
    logic              busy = 1'b0;
    logic              out_en = 1'b0;
    logic              zero_err;
    logic              sat_err;

    avg_feed dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .f_end    (f_end),
        .s_ready  (s_ready),
        .in_en    (in_en),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .out_en   (out_en),
        .zero_err (zero_err),
        .sat_err  (sat_err)
    );

    always #5 clk = ~clk;

    localparam int MAX_CNT = 16383;
    localparam int NEVER   = 32'h7fffffff;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;

    // Reference model: frames still owed to the divider, in order.
    int     exp_sum_q[$];
    int     exp_cnt_q[$];
    int     m_sum = 0;
    int     m_cnt = 0;
    int     sat_cyc = NEVER;
    bit     ze_mark[4];

    // Divider model.
    int     dstate = 0;
    int     wcnt = 0;
    int     bcnt = 0;
    int     req_delay = 0;
    int     busy_len = 3;
    bit     rand_div = 1'b0;
    longint last_dvd = 0;
    longint last_dvs = 0;
    longint last_ratio = 0;
    int     n_issued = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle output comparison, taken on the falling edge.
    task automatic compare_outputs();
        check("zero_err", {63'd0, zero_err}, {63'd0, ze_mark[cyc % 4]});
        check("sat_err", {63'd0, sat_err}, {63'd0, (cyc >= sat_cyc)});
    endtask

    task automatic div_step();
        case (dstate)
            0: begin
                out_en = 1'b0;
                if (in_en) begin
                    if (exp_sum_q.size() == 0) begin
                        check("in_en_no_frame", {63'd0, in_en}, 64'd0);
                    end else begin
                        check("dividend", 64'(dividend), 64'(exp_sum_q[0]));
                        check("divisor", 64'(divisor), 64'(exp_cnt_q[0]));
                    end
                    if (wcnt >= req_delay) begin
                        busy       = 1'b1;
                        last_dvd   = longint'(dividend);
                        last_dvs   = longint'(divisor);
                        last_ratio = (last_dvs == 0) ? 0 : (last_dvd <<< 12) / last_dvs;
                        if (exp_sum_q.size() != 0) begin
                            void'(exp_sum_q.pop_front());
                            void'(exp_cnt_q.pop_front());
                        end
                        n_issued++;
                        bcnt   = 0;
                        wcnt   = 0;
                        dstate = 1;
                    end else begin
                        wcnt++;
                    end
                end else if (wcnt != 0) begin
                    check("in_en_held", {63'd0, in_en}, 64'd1);
                    wcnt = 0;
                end
            end
            1: begin
                check("in_en_wait", {63'd0, in_en}, 64'd0);
                bcnt++;
                if (bcnt >= busy_len) begin
                    busy   = 1'b0;
                    out_en = 1'b1;
                    dstate = 2;
                end
            end
            default: begin
                out_en = 1'b0;
                check("in_en_done", {63'd0, in_en}, 64'd0);
                dstate = 0;
                if (rand_div) begin
                    req_delay = $urandom_range(0, 4);
                    busy_len  = $urandom_range(1, 6);
                end
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
        cyc++;
        ze_mark[(cyc + 1) % 4] = 1'b0;
        div_step();
    endtask

    task automatic send(input bit v, input int d, input bit fe);
        int tries = 0;
        while (!s_ready) begin
            tick();
            tries++;
            if (tries > 500) begin
                check("s_ready_timeout", {63'd0, s_ready}, 64'd1);
                return;
            end
        end
        s_valid = v;
        s_data  = DIV_SW'(d);
        f_end   = fe;
        if (v) begin
            if (m_cnt < MAX_CNT) begin
                m_sum += d;
                m_cnt++;
            end else if (sat_cyc == NEVER) begin
                sat_cyc = cyc + 1;
            end
        end
        if (fe) begin
            if (m_cnt == 0) begin
                ze_mark[(cyc + 1) % 4] = 1'b1;
            end else begin
                exp_sum_q.push_back(m_sum);
                exp_cnt_q.push_back(m_cnt);
            end
            m_sum = 0;
            m_cnt = 0;
        end
        tick();
        s_valid = 1'b0;
        f_end   = 1'b0;
        s_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        int tries = 0;
        while ((exp_sum_q.size() != 0 || dstate != 0) && tries < 3000) begin
            tick();
            tries++;
        end
        check("drain_left", 64'(exp_sum_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        reset   = 1'b1;
        s_valid = 1'b0;
        f_end   = 1'b0;
        busy    = 1'b0;
        out_en  = 1'b0;
        #1;
        check("rst_in_en", {63'd0, in_en}, 64'd0);
        check("rst_dividend", 64'(dividend), 64'd0);
        check("rst_divisor", 64'(divisor), 64'd0);
        check("rst_s_ready", {63'd0, s_ready}, 64'd1);
        check("rst_sat_err", {63'd0, sat_err}, 64'd0);
        check("rst_zero_err", {63'd0, zero_err}, 64'd0);
        exp_sum_q.delete();
        exp_cnt_q.delete();
        m_sum   = 0;
        m_cnt   = 0;
        sat_cyc = NEVER;
        for (int i = 0; i < 4; i++) ze_mark[i] = 1'b0;
        dstate  = 0;
        wcnt    = 0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n0;
        int len;
        bit merge;

        for (int i = 0; i < 4; i++) ze_mark[i] = 1'b0;
        reset_dut();

        // Three samples then a bare frame end.
        send(1, 10, 0);
        send(1, 20, 0);
        send(1, 30, 0);
        send(0, 0, 1);
        check("model_sum_60", 64'(exp_sum_q[0]), 64'd60);
        check("in_en_latency_t1", {63'd0, in_en}, 64'd0);
        drain();
        check("div_a_dividend", 64'(last_dvd), 64'd60);
        check("div_a_divisor", 64'(last_dvs), 64'd3);
        check("div_a_ratio", 64'(last_ratio), 64'h014000);

        // Frame end carried with the last sample.
        send(1, 5, 0);
        send(1, 7, 1);
        drain();
        check("div_b_dividend", 64'(last_dvd), 64'd12);
        check("div_b_divisor", 64'(last_dvs), 64'd2);

        // Empty frame.
        n0 = n_issued;
        send(0, 0, 1);
        check("zero_err_pulse", {63'd0, zero_err}, 64'd1);
        tick();
        check("zero_err_drop", {63'd0, zero_err}, 64'd0);
        idle(5);
        check("zero_no_request", 64'(n_issued), 64'(n0));

        // Back-to-back frames while the divider stays busy.
        busy_len  = 20;
        req_delay = 0;
        n0 = n_issued;
        send(1, 1, 0);
        send(1, 2, 1);
        send(1, 3, 0);
        send(1, 4, 1);
        send(1, 5, 0);
        send(1, 6, 1);
        check("hold_s_ready", {63'd0, s_ready}, 64'd0);
        drain();
        check("three_issued", 64'(n_issued - n0), 64'd3);
        check("third_dividend", 64'(last_dvd), 64'd11);
        busy_len = 3;

        // Saturation.
        repeat (16384) send(1, 255, 0);
        send(0, 0, 1);
        check("sat_err_set", {63'd0, sat_err}, 64'd1);
        drain();
        check("sat_dividend", 64'(last_dvd), 64'd4177665);
        check("sat_divisor", 64'(last_dvs), 64'd16383);

        // Reset while a request is outstanding.
        reset_dut();
        req_delay = 50;
        send(1, 9, 0);
        send(1, 9, 1);
        n0 = 0;
        while (!in_en && n0 < 10) begin
            tick();
            n0++;
        end
        check("req_reached", {63'd0, in_en}, 64'd1);
        reset_dut();
        req_delay = 0;
        send(1, 1, 0);
        send(1, 2, 1);
        drain();
        check("post_rst_dividend", 64'(last_dvd), 64'd3);
        check("post_rst_divisor", 64'(last_dvs), 64'd2);

        // Randomized frame stream with a randomly paced divider.
        rand_div = 1'b1;
        for (int f = 0; f < 300; f++) begin
            len   = $urandom_range(0, 6);
            merge = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send(1, $urandom_range(0, 255), (merge && k == len - 1));
            end
            if (!merge || len == 0) send(0, 0, 1);
        end
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
